// File: rtl/arbiter2to1_stream_if.sv
// Handshake bundle between two producers, the arbiter and one consumer.
//
// Signals:
//   request_valid  [1:0]               bit i: requester i presents a beat
//   request_data   [2*DATA_WIDTH-1:0]  requester i beat at [i*DATA_WIDTH +: DATA_WIDTH]
//   request_ready  [1:0]               bit i: beat from requester i accepted this cycle
//   output_valid                       output register holds a beat
//   output_data    [DATA_WIDTH-1:0]    registered beat
//   output_ready                       downstream accepts the held beat
//   selection                          current grant, drives the shared 2-to-1 mux select
//   busy                               arbiter is in a grant state
//
// Modports: slave = arbiter side, master = producers/consumer side.
interface arbiter2to1_stream_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [1:0]              request_valid;
   logic [2*DATA_WIDTH-1:0] request_data;
   logic [1:0]              request_ready;
   logic                    output_valid;
   logic [DATA_WIDTH-1:0]   output_data;
   logic                    output_ready;
   logic                    selection;
   logic                    busy;

   modport slave (
      input  request_valid, request_data, output_ready,
      output request_ready, output_valid, output_data, selection, busy
   );

   modport master (
      output request_valid, request_data, output_ready,
      input  request_ready, output_valid, output_data, selection, busy
   );
endinterface

// File: rtl/arbiter2to1_stream.sv
// Two-requester round-robin arbiter with a one-entry registered output stage.
// A grant is held for up to MAX_BURST consecutive beats while the other
// requester waits; handing the grant over after an expired burst costs one
// no-accept turnaround cycle.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      arbiter2to1_stream_if.slave (request/output handshakes, selection, busy)
//
// Optional (macro ARBITER2TO1_STREAM_TRANSFER_COUNTERS_EN):
//   clear_counters   synchronous clear of both counters, wins over an increment
//   transfer_count0  accepted beats from requester 0, 16-bit wrapping
//   transfer_count1  accepted beats from requester 1, 16-bit wrapping
module arbiter2to1_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 4
) (
   input logic clock,
   input logic reset_n,
   arbiter2to1_stream_if.slave bus
`ifdef ARBITER2TO1_STREAM_TRANSFER_COUNTERS_EN
   ,
   input  logic        clear_counters,
   output logic [15:0] transfer_count0,
   output logic [15:0] transfer_count1
`endif
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StGrant0 = 2'd1;
   localparam logic [1:0] StGrant1 = 2'd2;

   localparam logic [7:0] BurstMax = 8'(MAX_BURST);

   logic [1:0]            state_q, state_d;
   logic                  last_served_q, last_served_d;
   logic [7:0]            burst_q, burst_d;
   logic                  turn_q, turn_d;
   logic                  sel_q, sel_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic       granted;
   logic       cur;
   logic       cur_valid;
   logic       other_valid;
   logic [1:0] other_state;
   logic       accept;
   logic       transfer;

   always_comb begin
      granted     = (state_q == StGrant0) || (state_q == StGrant1);
      cur         = (state_q == StGrant1);
      cur_valid   = bus.request_valid[cur];
      other_valid = bus.request_valid[~cur];
      other_state = cur ? StGrant0 : StGrant1;
      // Turnaround cycle after a burst handover accepts nothing.
      accept      = granted && !turn_q && (!out_valid_q || bus.output_ready);
      transfer    = accept && cur_valid;
   end

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      burst_d       = burst_q;
      turn_d        = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.request_valid == 2'b11) begin
               state_d = last_served_q ? StGrant0 : StGrant1;
            end else if (bus.request_valid[0]) begin
               state_d = StGrant0;
            end else if (bus.request_valid[1]) begin
               state_d = StGrant1;
            end
         end
         StGrant0, StGrant1: begin
            if (!cur_valid) begin
               state_d = other_valid ? other_state : StIdle;
               burst_d = 8'd0;
            end else if (transfer) begin
               last_served_d = cur;
               if (burst_q + 8'd1 == BurstMax) begin
                  burst_d = 8'd0;
                  if (other_valid) begin
                     state_d = other_state;
                     turn_d  = 1'b1;
                  end
               end else begin
                  burst_d = burst_q + 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Selection follows the grant and keeps its last value through IDLE.
   always_comb begin
      sel_d = sel_q;
      if (state_d != StIdle) begin
         sel_d = (state_d == StGrant1);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (transfer) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.request_data[cur*DATA_WIDTH +: DATA_WIDTH];
      end else if (bus.output_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         last_served_q <= 1'b1;
         burst_q       <= 8'd0;
         turn_q        <= 1'b0;
         sel_q         <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         burst_q       <= burst_d;
         turn_q        <= turn_d;
         sel_q         <= sel_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

   assign bus.request_ready = accept ? (cur ? 2'b10 : 2'b01) : 2'b00;
   assign bus.output_valid  = out_valid_q;
   assign bus.output_data   = out_data_q;
   assign bus.selection     = sel_q;
   assign bus.busy          = granted;

`ifdef ARBITER2TO1_STREAM_TRANSFER_COUNTERS_EN
   logic [15:0] count0_q, count1_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count0_q <= 16'd0;
         count1_q <= 16'd0;
      end else if (clear_counters) begin
         count0_q <= 16'd0;
         count1_q <= 16'd0;
      end else if (transfer) begin
         if (cur) count1_q <= count1_q + 16'd1;
         else     count0_q <= count0_q + 16'd1;
      end
   end

   assign transfer_count0 = count0_q;
   assign transfer_count1 = count1_q;
`endif

endmodule

// File: tb/tb_arbiter2to1_stream.sv
module tb_arbiter2to1_stream;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   arbiter2to1_stream_if #(.DATA_WIDTH(8)) bus ();

`ifdef ARBITER2TO1_STREAM_TRANSFER_COUNTERS_EN
   logic        clear_counters = 1'b0;
   logic [15:0] transfer_count0;
   logic [15:0] transfer_count1;
`endif

   arbiter2to1_stream #(
      .DATA_WIDTH(8),
      .MAX_BURST (4)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
`ifdef ARBITER2TO1_STREAM_TRANSFER_COUNTERS_EN
      ,
      .clear_counters (clear_counters),
      .transfer_count0(transfer_count0),
      .transfer_count1(transfer_count1)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Producer model: requester i offers base_i + idx_i while idx_i < lim_i.
   int         idx0, idx1, lim0, lim1;
   logic [7:0] base0, base1;
   logic [1:0] seen_ready, seen_valid;

   int         tie_ready [21] = '{0,1,1,1,1,0,2,2,2,2,0,1,1,1,1,0,2,2,2,2,2};
   bit         tie_ov    [21] = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0};
   bit         tie_sel   [21] = '{0,0,0,0,1,1,1,1,1,0,0,0,0,0,1,1,1,1,1,1,1};
   logic [7:0] tie_data  [16] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                                  8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setup(input int l0, input logic [7:0] b0, input int l1, input logic [7:0] b1);
      idx0  = 0;
      idx1  = 0;
      lim0  = l0;
      lim1  = l1;
      base0 = b0;
      base1 = b1;
   endtask

   task automatic drive();
      bus.request_valid = {idx1 < lim1, idx0 < lim0};
      bus.request_data  = {base1 + 8'(idx1), base0 + 8'(idx0)};
   endtask

   // Cycle phase 1: drive, settle, remember what the DUT accepted.
   task automatic pre_edge(input bit ordy);
      drive();
      bus.output_ready = ordy;
      #1;
      seen_ready = bus.request_ready;
      seen_valid = bus.request_valid;
   endtask

   // Cycle phase 2: clock edge, then advance producers past accepted beats.
   task automatic post_edge();
      @(posedge clock);
      #1;
      if (seen_ready[0] && seen_valid[0]) idx0++;
      if (seen_ready[1] && seen_valid[1]) idx1++;
   endtask

   task automatic cyc(input bit ordy, input logic [1:0] e_ready, input bit e_ov,
                      input logic [7:0] e_data, input bit e_sel);
      pre_edge(ordy);
      chk("request_ready", bus.request_ready, e_ready);
      post_edge();
      chk("output_valid", bus.output_valid, e_ov);
      if (e_ov) chk("output_data", bus.output_data, e_data);
      chk("selection", bus.selection, e_sel);
   endtask

   initial begin
      int k;
      setup(0, 8'h00, 0, 8'h00);
      bus.request_valid = 2'b00;
      bus.request_data  = '0;
      bus.output_ready  = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_output_valid", bus.output_valid, 1'b0);
      chk("rst_output_data", bus.output_data, 8'h00);
      chk("rst_request_ready", bus.request_ready, 2'b00);
      chk("rst_selection", bus.selection, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      reset_n = 1'b1;

      // Tie from IDLE: requester 0 wins first, bursts of 4 with a turnaround gap
      setup(8, 8'hA0, 8, 8'hB0);
      k = 0;
      for (int c = 0; c < 21; c++) begin
         cyc(1'b1, 2'(tie_ready[c]), tie_ov[c], tie_ov[c] ? tie_data[k] : 8'h00, tie_sel[c]);
         if (tie_ov[c]) k++;
         if (c == 0) chk("tie_busy", bus.busy, 1'b1);
      end
      pre_edge(1'b1);
      post_edge();
      chk("tie_idle_busy", bus.busy, 1'b0);

      // Single requester: 10 beats with no gaps across burst wraps
      setup(0, 8'h00, 10, 8'hB0);
      cyc(1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 2'b10, 1'b1, 8'hB0 + 8'(i), 1'b1);
      cyc(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
      chk("single_idle_busy", bus.busy, 1'b0);

      // Backpressure in GRANT0
      setup(4, 8'hC0, 0, 8'h00);
      cyc(1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 2'b01, 1'b1, 8'hC0, 1'b0);
      repeat (3) cyc(1'b0, 2'b00, 1'b1, 8'hC0, 1'b0);
      cyc(1'b1, 2'b01, 1'b1, 8'hC1, 1'b0);
      cyc(1'b1, 2'b01, 1'b1, 8'hC2, 1'b0);
      cyc(1'b1, 2'b01, 1'b1, 8'hC3, 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 8'h00, 1'b0);

      // Tie after requester 0 was served last goes to requester 1
      setup(1, 8'hF0, 1, 8'hF8);
      cyc(1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
      cyc(1'b1, 2'b10, 1'b1, 8'hF8, 1'b1);
      cyc(1'b1, 2'b10, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 2'b01, 1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 8'h00, 1'b0);

      // Release: requester 0 drops valid after 2 beats while requester 1 waits
      setup(2, 8'hD0, 0, 8'hE0);
      cyc(1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 2'b01, 1'b1, 8'hD0, 1'b0);
      lim1 = 2;
      cyc(1'b1, 2'b01, 1'b1, 8'hD1, 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 8'h00, 1'b1);
      cyc(1'b1, 2'b10, 1'b1, 8'hE0, 1'b1);
      cyc(1'b1, 2'b10, 1'b1, 8'hE1, 1'b1);
      cyc(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);

      // Reset mid-stream with a held beat
      setup(0, 8'h00, 3, 8'h20);
      cyc(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 2'b10, 1'b1, 8'h20, 1'b1);
      drive();
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_output_valid", bus.output_valid, 1'b0);
      chk("midrst_output_data", bus.output_data, 8'h00);
      chk("midrst_request_ready", bus.request_ready, 2'b00);
      chk("midrst_selection", bus.selection, 1'b0);
      chk("midrst_busy", bus.busy, 1'b0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      setup(1, 8'h30, 0, 8'h00);
      cyc(1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
      chk("postrst_busy", bus.busy, 1'b1);
      cyc(1'b1, 2'b01, 1'b1, 8'h30, 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 8'h00, 1'b0);

`ifdef ARBITER2TO1_STREAM_TRANSFER_COUNTERS_EN
      // Transfer counters
      begin
         int budget;
         clear_counters = 1'b1;
         setup(0, 8'h00, 0, 8'h00);
         pre_edge(1'b1);
         post_edge();
         clear_counters = 1'b0;
         chk("cnt_clear0", transfer_count0, 16'd0);
         chk("cnt_clear1", transfer_count1, 16'd0);
         setup(5, 8'h40, 3, 8'h50);
         budget = 0;
         while (!(idx0 == 5 && idx1 == 3) && budget < 40) begin
            pre_edge(1'b1);
            post_edge();
            budget++;
         end
         chk("cnt_done", (idx0 == 5 && idx1 == 3), 1'b1);
         repeat (2) begin
            pre_edge(1'b1);
            post_edge();
         end
         chk("cnt_count0", transfer_count0, 16'd5);
         chk("cnt_count1", transfer_count1, 16'd3);
         setup(1, 8'h60, 0, 8'h00);
         pre_edge(1'b1);
         post_edge();
         clear_counters = 1'b1;
         pre_edge(1'b1);
         chk("cnt_beat_ready", bus.request_ready, 2'b01);
         post_edge();
         clear_counters = 1'b0;
         chk("cnt_clear_wins0", transfer_count0, 16'd0);
         chk("cnt_clear_wins1", transfer_count1, 16'd0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
